// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared state encoding, widths and ALU op codes
package alu_arb_pkg;

  localparam int DATA_W   = 32;
  localparam int ALU_OP_W = 6;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 6'h20;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 6'h22;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 6'h24;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 6'h25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-port grant, round-robin or fixed priority to port 0
module rr_arbiter2 #(
  parameter int RR_ENABLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // 1 = port 1 wins the next contention; only moves when a grant is taken
  logic prio;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ((RR_ENABLE != 0) && prio) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter in front of one shared registered ALU
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int RR_ENABLE = 1,
  parameter int ALUOP_W   = ALU_OP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [ALUOP_W-1:0] req_op0,
  input  logic [ALUOP_W-1:0] req_op1,
  input  logic [DATA_W-1:0]  req_a0,
  input  logic [DATA_W-1:0]  req_a1,
  input  logic [DATA_W-1:0]  req_b0,
  input  logic [DATA_W-1:0]  req_b1,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [DATA_W-1:0]  rsp_result,
  output logic               rsp_zero,
  output logic               rsp_ov,
  output logic [ALUOP_W-1:0] alu_control,
  output logic [DATA_W-1:0]  alu_src0,
  output logic [DATA_W-1:0]  alu_src1,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  input  logic               alu_ov
);

  arb_state_t state;
  logic       owner;
  logic [1:0] grant;
  logic       accept;
  logic       acc_port;

  rr_arbiter2 #(.RR_ENABLE(RR_ENABLE)) u_grant (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  // reset is folded in so ready drops the instant reset goes low
  assign req_ready = ((state == ST_IDLE) && reset) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign acc_port  = req_ready[1];

  // ALU inputs are only written on accept, so they hold through CAPT and between ops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      rsp_valid   <= 2'b00;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_ov      <= 1'b0;
      alu_control <= '0;
      alu_src0    <= '0;
      alu_src1    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_control <= acc_port ? req_op1 : req_op0;
            alu_src0    <= acc_port ? req_a1  : req_a0;
            alu_src1    <= acc_port ? req_b1  : req_b0;
            owner       <= acc_port;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_ov     <= alu_ov;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a registered ALU model
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  typedef struct packed {
    logic        port;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  rsp_ready = 2'b00;
  logic [1:0]  f_rsp_ready = 2'b11;
  logic [5:0]  req_op0 = '0, req_op1 = '0;
  logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;

  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_ov;
  logic [5:0]  alu_control;
  logic [31:0] alu_src0, alu_src1, alu_result;
  logic        alu_zero, alu_ov;

  logic [1:0]  f_req_ready, f_rsp_valid;
  logic [31:0] f_rsp_result;
  logic        f_rsp_zero, f_rsp_ov;
  logic [5:0]  f_alu_control;
  logic [31:0] f_alu_src0, f_alu_src1, f_alu_result;
  logic        f_alu_zero, f_alu_ov;

  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   acc_port_q[$];
  int   acc_cyc_q[$];
  int   fp_port_q[$];

  always #5 clk = ~clk;

  alu_arbiter #(.RR_ENABLE(1), .ALUOP_W(6)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ov(rsp_ov),
    .alu_control(alu_control), .alu_src0(alu_src0), .alu_src1(alu_src1),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ov(alu_ov)
  );

  alu_arbiter #(.RR_ENABLE(0), .ALUOP_W(6)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(f_req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready),
    .rsp_result(f_rsp_result), .rsp_zero(f_rsp_zero), .rsp_ov(f_rsp_ov),
    .alu_control(f_alu_control), .alu_src0(f_alu_src0), .alu_src1(f_alu_src1),
    .alu_result(f_alu_result), .alu_zero(f_alu_zero), .alu_ov(f_alu_ov)
  );

  // {result, zero, ov}
  function automatic logic [33:0] alu_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ov;
    ov = 1'b0;
    case (op)
      ALU_ADD: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      default: r = '0;
    endcase
    return {r, (r == 32'd0), ov};
  endfunction

  // shared ALU: registered result and zero, combinational overflow
  logic [33:0] alu_f, f_alu_f;
  assign alu_f    = alu_ref(alu_control, alu_src0, alu_src1);
  assign f_alu_f  = alu_ref(f_alu_control, f_alu_src0, f_alu_src1);
  assign alu_ov   = alu_f[0];
  assign f_alu_ov = f_alu_f[0];
  always_ff @(posedge clk) begin
    alu_result   <= alu_f[33:2];
    alu_zero     <= alu_f[1];
    f_alu_result <= f_alu_f[33:2];
    f_alu_zero   <= f_alu_f[1];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    cyc++;
    if (reset) begin
      if (req_valid[0] && req_ready[0]) begin
        e.port = 1'b0;
        {e.res, e.z, e.ov} = alu_ref(req_op0, req_a0, req_b0);
        exp_q.push_back(e);
        acc_port_q.push_back(0);
        acc_cyc_q.push_back(cyc);
      end
      if (req_valid[1] && req_ready[1]) begin
        e.port = 1'b1;
        {e.res, e.z, e.ov} = alu_ref(req_op1, req_a1, req_b1);
        exp_q.push_back(e);
        acc_port_q.push_back(1);
        acc_cyc_q.push_back(cyc);
      end
      if (req_valid[0] && f_req_ready[0]) fp_port_q.push_back(0);
      if (req_valid[1] && f_req_ready[1]) fp_port_q.push_back(1);
      for (int p = 0; p < 2; p++) begin
        if (rsp_valid[p] && rsp_ready[p]) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("sb_port", 64'(p), 64'(e.port));
            chk("sb_result", 64'(rsp_result), 64'(e.res));
            chk("sb_zero", 64'(rsp_zero), 64'(e.z));
            chk("sb_ov", 64'(rsp_ov), 64'(e.ov));
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'(0));
    chk({tag, "_rsp_zero"}, 64'(rsp_zero), 64'(0));
    chk({tag, "_rsp_ov"}, 64'(rsp_ov), 64'(0));
    chk({tag, "_alu_control"}, 64'(alu_control), 64'(0));
    chk({tag, "_alu_src0"}, 64'(alu_src0), 64'(0));
    chk({tag, "_alu_src1"}, 64'(alu_src1), 64'(0));
  endtask

  task automatic issue(input int p, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int n0;
    n0 = acc_port_q.size();
    if (p == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
    req_valid[p] = 1'b1;
    @(negedge clk);
    req_valid[p] = 1'b0;
    chk("issue_accept", 64'(acc_port_q.size()), 64'(n0 + 1));
  endtask

  task automatic wait_rsp(input int p);
    int k;
    k = 0;
    while (!rsp_valid[p] && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_wait", 64'(rsp_valid[p]), 64'(1));
  endtask

  initial begin
    int n0;
    // reset state, with requests asserted to prove ready stays low
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    req_valid = 2'b00;

    // ADD 5+7 on port 0 in the first IDLE cycle after release
    reset = 1'b1;
    req_op0 = ALU_ADD; req_a0 = 32'd5; req_b0 = 32'd7;
    req_valid = 2'b01;
    #1 chk("first_ready", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    req_valid = 2'b00;
    chk("exec_control", 64'(alu_control), 64'(ALU_ADD));
    chk("exec_src0", 64'(alu_src0), 64'(5));
    chk("exec_src1", 64'(alu_src1), 64'(7));
    chk("exec_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("capt_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("capt_control_held", 64'(alu_control), 64'(ALU_ADD));
    @(negedge clk);
    chk("n3_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    chk("n3_result", 64'(rsp_result), 64'(12));
    chk("n3_zero", 64'(rsp_zero), 64'(0));
    chk("n3_ov", 64'(rsp_ov), 64'(0));
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("done_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("idle_src0_held", 64'(alu_src0), 64'(5));

    // overflow ADD held in RESP; wrong-port ready and new requests ignored
    rsp_ready = 2'b10;
    issue(0, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_rsp(0);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_rsp_valid", 64'(rsp_valid), 64'(2'b01));
      chk("hold_result", 64'(rsp_result), 64'(32'h8000_0000));
      chk("hold_ov", 64'(rsp_ov), 64'(1));
      chk("hold_zero", 64'(rsp_zero), 64'(0));
      chk("hold_req_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("hold_release", 64'(rsp_valid), 64'(0));

    // SUB 3-3 on port 1
    rsp_ready = 2'b11;
    issue(1, ALU_SUB, 32'd3, 32'd3);
    wait_rsp(1);
    chk("sub_rsp_valid", 64'(rsp_valid), 64'(2'b10));
    chk("sub_result", 64'(rsp_result), 64'(0));
    chk("sub_zero", 64'(rsp_zero), 64'(1));
    chk("sub_ov", 64'(rsp_ov), 64'(0));
    @(negedge clk);
    chk("sub_done", 64'(rsp_valid), 64'(0));

    // a request withdrawn before the edge is not taken
    req_valid = 2'b10;
    #1 chk("withdraw_ready", 64'(req_ready), 64'(2'b10));
    #1 req_valid = 2'b00;
    #1 chk("withdraw_ready_low", 64'(req_ready), 64'(0));
    n0 = acc_port_q.size();
    @(negedge clk);
    chk("withdraw_no_accept", 64'(acc_port_q.size()), 64'(n0));

    // continuous contention: round-robin vs fixed priority
    acc_port_q.delete(); acc_cyc_q.delete(); fp_port_q.delete();
    req_op0 = ALU_ADD; req_a0 = 32'd10; req_b0 = 32'd20;
    req_op1 = ALU_SUB; req_a1 = 32'd50; req_b1 = 32'd8;
    req_valid = 2'b11;
    repeat (17) @(negedge clk);
    req_valid = 2'b00;
    repeat (6) @(negedge clk);
    chk("rr_count", 64'(acc_port_q.size() >= 4), 64'(1));
    if (acc_port_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_grant", 64'(acc_port_q[i]), 64'(i % 2));
      for (int i = 1; i < 4; i++) chk("rr_interval", 64'(acc_cyc_q[i] - acc_cyc_q[i-1]), 64'(4));
    end
    chk("fp_count", 64'(fp_port_q.size() >= 3), 64'(1));
    if (fp_port_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) chk("fp_grant", 64'(fp_port_q[i]), 64'(0));
    end

    // reset during CAPT after a port 0 accept (pointer would otherwise favour port 1)
    rsp_ready = 2'b00;
    issue(0, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
    @(negedge clk);
    req_valid = 2'b11;
    #2 reset = 1'b0;
    #1 check_all_zero("mid_reset");
    exp_q.delete();
    req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("post_reset_no_rsp", 64'(rsp_valid), 64'(0));
      @(negedge clk);
    end
    acc_port_q.delete();
    req_valid = 2'b11;
    #1 chk("post_reset_ready", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    req_valid = 2'b00;
    chk("post_reset_count", 64'(acc_port_q.size()), 64'(1));
    if (acc_port_q.size() >= 1) chk("post_reset_port", 64'(acc_port_q[0]), 64'(0));
    wait_rsp(0);
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
